// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display sharing arbiter.
package disp_pkg;

  localparam int DISP_DIGITS   = 8;
  localparam int DISP_NIBBLE_W = 4;
  localparam int DISP_DATA_W   = 32;

  // One-hot so each grant output maps onto a single state bit.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHOW0 = 3'b010,
    SHOW1 = 3'b100
  } disp_arb_state_t;

  function automatic logic [DISP_NIBBLE_W-1:0] disp_nibble(
    input logic [DISP_DATA_W-1:0] word,
    input int                     idx
  );
    return word[idx*DISP_NIBBLE_W +: DISP_NIBBLE_W];
  endfunction

endpackage

// File: rtl/disp_hold_timer.sv
// Minimum on-screen hold timer: counts cycles since the last grant change and
// saturates at HOLD_CYCLES so it never wraps while an owner keeps the display.
module disp_hold_timer #(
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic mclk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES);

  logic [CNT_W-1:0] count;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (run && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_MAX);

endmodule

// File: rtl/disp_share_arb.sv
// Two-requester time-share arbiter for the 8-digit display with a minimum hold.
// Build option DISP_SHARE_ARB_IDLE_KEEP_EN: keep the last owner's digits in IDLE.
module disp_share_arb
  import disp_pkg::*;
#(
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] digits,
  output logic        busy
);

  disp_arb_state_t        state;
  disp_arb_state_t        next_state;
  logic                   expired;
  logic                   restart;
  logic                   run;
  logic [DISP_DATA_W-1:0] next_digits;
  logic [DISP_DATA_W-1:0] idle_digits;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req0) begin
          next_state = SHOW0;
        end else if (req1) begin
          next_state = SHOW1;
        end
      end
      // After expiry the other requester wins even if the owner still asks.
      SHOW0: begin
        if (expired) begin
          if (req1) begin
            next_state = SHOW1;
          end else if (!req0) begin
            next_state = IDLE;
          end
        end
      end
      SHOW1: begin
        if (expired) begin
          if (req0) begin
            next_state = SHOW0;
          end else if (!req1) begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign restart = (next_state != state);
  assign run     = (state == SHOW0) || (state == SHOW1);

  disp_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .mclk   (mclk),
    .rst    (rst),
    .restart(restart),
    .run    (run),
    .expired(expired)
  );

`ifdef DISP_SHARE_ARB_IDLE_KEEP_EN
  assign idle_digits = digits;
`else
  assign idle_digits = '0;
`endif

  // Digits follow the source that owns the display after this edge.
  for (genvar gi = 0; gi < DISP_DIGITS; gi++) begin : g_nibble
    assign next_digits[gi*DISP_NIBBLE_W +: DISP_NIBBLE_W] =
      (next_state == SHOW0) ? disp_nibble(data0, gi) :
      (next_state == SHOW1) ? disp_nibble(data1, gi) :
                              disp_nibble(idle_digits, gi);
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      busy   <= 1'b0;
      digits <= '0;
    end else begin
      state  <= next_state;
      gnt0   <= (next_state == SHOW0);
      gnt1   <= (next_state == SHOW1);
      busy   <= (next_state != IDLE);
      digits <= next_digits;
    end
  end

endmodule

// File: tb/tb_disp_share_arb.sv
// Directed self-checking bench for disp_share_arb with a hold of 8 cycles.
module tb_disp_share_arb;

  localparam int HOLD = 8;

  logic        mclk = 1'b0;
  logic        rst  = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [31:0] data0 = '0;
  logic [31:0] data1 = '0;
  logic        gnt0;
  logic        gnt1;
  logic        busy;
  logic [31:0] digits;

  int checks   = 0;
  int failures = 0;

  always #5 mclk = ~mclk;

  disp_share_arb #(
    .HOLD_CYCLES(HOLD)
  ) dut (
    .mclk  (mclk),
    .rst   (rst),
    .req0  (req0),
    .data0 (data0),
    .req1  (req1),
    .data1 (data1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .digits(digits),
    .busy  (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e0, input logic e1, input logic [31:0] ed);
    check({tag, " gnt0"},   32'(gnt0), 32'(e0));
    check({tag, " gnt1"},   32'(gnt1), 32'(e1));
    check({tag, " busy"},   32'(busy), 32'(e0 | e1));
    check({tag, " digits"}, digits, ed);
    check({tag, " excl"},   32'(gnt0 & gnt1), 32'd0);
  endtask

  function automatic logic [31:0] idle_exp(input logic [31:0] last);
`ifdef DISP_SHARE_ARB_IDLE_KEEP_EN
    return last;
`else
    return (last & 32'h0);
`endif
  endfunction

  initial begin
    // Reset state
    step();
    step();
    check_outs("reset", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    step();
    check_outs("post-reset idle", 1'b0, 1'b0, 32'h0);

    // Single requester, live data, release before expiry
    req0  = 1'b1;
    data0 = 32'h4321DCBA;
    step();
    check_outs("t2 grant", 1'b1, 1'b0, 32'h4321DCBA);
    data0 = 32'h00000005;
    step();
    check_outs("t2 live", 1'b1, 1'b0, 32'h00000005);
    req0 = 1'b0;
    for (int k = 2; k <= HOLD; k++) begin
      step();
      check_outs($sformatf("t2 hold e%0d", k), 1'b1, 1'b0, 32'h00000005);
    end
    step();
    check_outs("t2 release", 1'b0, 1'b0, idle_exp(32'h00000005));

    // Tie from IDLE, fairness swaps both ways
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 32'hA0A0A0A0;
    data1 = 32'hB1B1B1B1;
    step();
    check_outs("t3 grant0", 1'b1, 1'b0, 32'hA0A0A0A0);
    for (int k = 1; k <= HOLD; k++) begin
      step();
      check_outs($sformatf("t3 hold0 e%0d", k), 1'b1, 1'b0, 32'hA0A0A0A0);
    end
    step();
    check_outs("t3 swap1 e9", 1'b0, 1'b1, 32'hB1B1B1B1);
    for (int k = 1; k <= HOLD; k++) begin
      step();
      check_outs($sformatf("t3 hold1 e%0d", k + 9), 1'b0, 1'b1, 32'hB1B1B1B1);
    end
    step();
    check_outs("t3 swap0 e18", 1'b1, 1'b0, 32'hA0A0A0A0);
    req0 = 1'b0;
    req1 = 1'b0;
    for (int k = 1; k <= HOLD; k++) begin
      step();
      check_outs($sformatf("t3 drain e%0d", k + 18), 1'b1, 1'b0, 32'hA0A0A0A0);
    end
    step();
    check_outs("t3 idle", 1'b0, 1'b0, idle_exp(32'hA0A0A0A0));

    // Early release by requester 1 (idle digits depend on build option)
    req1  = 1'b1;
    data1 = 32'h0000BEEF;
    step();
    check_outs("t4 grant1", 1'b0, 1'b1, 32'h0000BEEF);
    step();
    check_outs("t4 e1", 1'b0, 1'b1, 32'h0000BEEF);
    req1 = 1'b0;
    for (int k = 2; k <= HOLD; k++) begin
      step();
      check_outs($sformatf("t4 hold e%0d", k), 1'b0, 1'b1, 32'h0000BEEF);
    end
    step();
    check_outs("t4 idle e9", 1'b0, 1'b0, idle_exp(32'h0000BEEF));
    step();
    check_outs("t4 idle stays", 1'b0, 1'b0, idle_exp(32'h0000BEEF));

    // Late arrival after expiry swaps at the next edge
    req0  = 1'b1;
    data0 = 32'h00C0FFEE;
    step();
    check_outs("t6 grant0", 1'b1, 1'b0, 32'h00C0FFEE);
    for (int k = 1; k < 20; k++) begin
      step();
      check_outs($sformatf("t6 own0 e%0d", k), 1'b1, 1'b0, 32'h00C0FFEE);
    end
    req1  = 1'b1;
    data1 = 32'h11112222;
    step();
    check_outs("t6 swap1", 1'b0, 1'b1, 32'h11112222);
    step();
    check_outs("t6 own1", 1'b0, 1'b1, 32'h11112222);

    // Asynchronous reset in the middle of SHOW1
    #3;
    rst = 1'b1;
    #1;
    check_outs("t1 async rst", 1'b0, 1'b0, 32'h0);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    rst = 1'b0;
    step();
    check_outs("t1 idle after rst", 1'b0, 1'b0, 32'h0);
    req1  = 1'b1;
    data1 = 32'h87654321;
    step();
    check_outs("t1 regrant1", 1'b0, 1'b1, 32'h87654321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
